// File: rtl/vga_timing_pkg.sv
// Shared VGA 640x480@60 Hz timing constants.
// Imported by the sync generator, the shape renderer and the output stage
// so every stage agrees on display bounds, porches and sync positions.
package vga_timing_pkg;

   // Counter width: both totals (800, 525) fit in 10 bits.
   localparam int CNT_W = 10;

   localparam int H_DISPLAY = 640;
   localparam int H_FRONT   = 16;
   localparam int H_SYNC    = 96;
   localparam int H_BACK    = 48;
   localparam int H_TOTAL   = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;   // 800

   localparam int V_DISPLAY = 480;
   localparam int V_FRONT   = 10;
   localparam int V_SYNC    = 2;
   localparam int V_BACK    = 33;
   localparam int V_TOTAL   = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;   // 525

   // Inclusive sync windows in pixel / line counts.
   localparam int H_SYNC_START = H_DISPLAY + H_FRONT;                  // 656
   localparam int H_SYNC_END   = H_DISPLAY + H_FRONT + H_SYNC - 1;     // 751
   localparam int V_SYNC_START = V_DISPLAY + V_FRONT;                  // 490
   localparam int V_SYNC_END   = V_DISPLAY + V_FRONT + V_SYNC - 1;     // 491

endpackage

// File: rtl/pixel_tick_gen.sv
// Pixel-enable divider: p_tick is high one cycle in every CLK_DIV system
// clocks, on the last count of the divider. With CLK_DIV=1 it is always high.
module pixel_tick_gen #(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic reset,
   output logic p_tick
);

   localparam int W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [W-1:0] DIV_LAST = W'(CLK_DIV - 1);

   logic [W-1:0] div_cnt_q;
   logic [W-1:0] div_cnt_d;

   assign p_tick = (div_cnt_q == DIV_LAST);

   // Next divider count: wrap on the tick cycle, otherwise advance.
   always_comb begin
      div_cnt_d = div_cnt_q + W'(1);
      if (p_tick) begin
         div_cnt_d = '0;
      end
   end

   // Divider register with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         div_cnt_q <= '0;
      end else begin
         div_cnt_q <= div_cnt_d;
      end
   end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: pixel enable, x/y scan counters, active-low
// hsync/vsync, video_on, and line/frame pulses for the shape renderer.
// Optional feature: define VGA_FRAME_CNT_EN to add the 8-bit frame_cnt output
// (used by the traffic controller for blink phases).
module vga_sync_gen
   import vga_timing_pkg::*;
#(
   parameter int CLK_DIV   = 4,
   parameter int H_DISPLAY = vga_timing_pkg::H_DISPLAY,
   parameter int H_FRONT   = vga_timing_pkg::H_FRONT,
   parameter int H_SYNC    = vga_timing_pkg::H_SYNC,
   parameter int H_BACK    = vga_timing_pkg::H_BACK,
   parameter int V_DISPLAY = vga_timing_pkg::V_DISPLAY,
   parameter int V_FRONT   = vga_timing_pkg::V_FRONT,
   parameter int V_SYNC    = vga_timing_pkg::V_SYNC,
   parameter int V_BACK    = vga_timing_pkg::V_BACK
) (
   input  logic             clk,
   input  logic             reset,
   output logic             p_tick,
   output logic [CNT_W-1:0] x,
   output logic [CNT_W-1:0] y,
   output logic             video_on,
   output logic             hsync,
   output logic             vsync,
   output logic             line_end,
   output logic             frame_start
`ifdef VGA_FRAME_CNT_EN
   ,
   output logic [7:0]       frame_cnt
`endif
);

   // Count-width constants derived from the timing parameters.
   localparam int HT = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
   localparam int VT = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
   localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(HT - 1);
   localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(VT - 1);
   localparam logic [CNT_W-1:0] H_DISP  = CNT_W'(H_DISPLAY);
   localparam logic [CNT_W-1:0] V_DISP  = CNT_W'(V_DISPLAY);
   localparam logic [CNT_W-1:0] H_SS    = CNT_W'(H_DISPLAY + H_FRONT);
   localparam logic [CNT_W-1:0] H_SE    = CNT_W'(H_DISPLAY + H_FRONT + H_SYNC - 1);
   localparam logic [CNT_W-1:0] V_SS    = CNT_W'(V_DISPLAY + V_FRONT);
   localparam logic [CNT_W-1:0] V_SE    = CNT_W'(V_DISPLAY + V_FRONT + V_SYNC - 1);

   logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
   logic [CNT_W-1:0] v_cnt_q, v_cnt_d;

   pixel_tick_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_tick (
      .clk    (clk),
      .reset  (reset),
      .p_tick (p_tick)
   );

   // Pulses are combinational so they coincide with the last pixel/line.
   assign line_end    = p_tick && (h_cnt_q == H_LAST);
   assign frame_start = line_end && (v_cnt_q == V_LAST);

   // Next-state scan counters: advance x on each pixel tick, y on line wrap.
   always_comb begin
      h_cnt_d = h_cnt_q;
      v_cnt_d = v_cnt_q;
      if (p_tick) begin
         if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            if (v_cnt_q == V_LAST) begin
               v_cnt_d = '0;
            end else begin
               v_cnt_d = v_cnt_q + CNT_W'(1);
            end
         end else begin
            h_cnt_d = h_cnt_q + CNT_W'(1);
         end
      end
   end

   // Scan counter registers; reset wins over any pending advance.
   always_ff @(posedge clk) begin
      if (reset) begin
         h_cnt_q <= '0;
         v_cnt_q <= '0;
      end else begin
         h_cnt_q <= h_cnt_d;
         v_cnt_q <= v_cnt_d;
      end
   end

   // Decode straight from the registered counts so syncs align with x/y.
   assign x        = h_cnt_q;
   assign y        = v_cnt_q;
   assign video_on = (h_cnt_q < H_DISP) && (v_cnt_q < V_DISP);
   assign hsync    = !((h_cnt_q >= H_SS) && (h_cnt_q <= H_SE));
   assign vsync    = !((v_cnt_q >= V_SS) && (v_cnt_q <= V_SE));

`ifdef VGA_FRAME_CNT_EN
   logic [7:0] frame_cnt_q, frame_cnt_d;

   // Frame counter advances once per frame and wraps naturally at 255.
   always_comb begin
      frame_cnt_d = frame_cnt_q;
      if (frame_start) begin
         frame_cnt_d = frame_cnt_q + 8'd1;
      end
   end

   // Frame counter register.
   always_ff @(posedge clk) begin
      if (reset) begin
         frame_cnt_q <= '0;
      end else begin
         frame_cnt_q <= frame_cnt_d;
      end
   end

   assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: three instances (default timing at CLK_DIV=4,
// a shrunken frame at CLK_DIV=2, default timing at CLK_DIV=1), checked
// cycle by cycle against a closed-form raster model through a queue.
module tb_vga_sync_gen;

   typedef struct packed {
      logic [9:0] x;
      logic [9:0] y;
      logic       tick;
      logic       vid;
      logic       hs;
      logic       vs;
      logic       le;
      logic       fs;
      logic [7:0] fc;
   } exp_t;

   // Small-frame instance geometry: 10 x 7 counts, 70 pixels per frame.
   localparam int B_DIV = 2;
   localparam int B_HD = 6, B_HF = 1, B_HS = 2, B_HB = 1;
   localparam int B_VD = 4, B_VF = 1, B_VS = 1, B_VB = 1;
   localparam int B_FRAME_CLKS = 10 * 7 * B_DIV;
`ifdef VGA_FRAME_CNT_EN
   localparam int B_FRAMES = 257;
`else
   localparam int B_FRAMES = 3;
`endif

   logic clk = 1'b0;
   logic rst_a = 1'b1, rst_b = 1'b1, rst_c = 1'b1;

   logic       tick_a, vid_a, hs_a, vs_a, le_a, fs_a;
   logic [9:0] x_a, y_a;
   logic       tick_b, vid_b, hs_b, vs_b, le_b, fs_b;
   logic [9:0] x_b, y_b;
   logic       tick_c, vid_c, hs_c, vs_c, le_c, fs_c;
   logic [9:0] x_c, y_c;
   logic [7:0] fc_a, fc_b, fc_c;

   int n_assert = 0;
   int n_fail   = 0;
   exp_t sb_q[$];

   // Observed-count accumulators, compared against constants at the end.
   int a_hs_low = 0, a_le = 0;
   int b_fs = 0, b_vid_ticks = 0, b_vs_low = 0;
   int c_le = 0, c_tick_low = 0;

   always #5 clk = ~clk;

   vga_sync_gen #(.CLK_DIV(4)) dut_a (
      .clk(clk), .reset(rst_a), .p_tick(tick_a), .x(x_a), .y(y_a),
      .video_on(vid_a), .hsync(hs_a), .vsync(vs_a),
      .line_end(le_a), .frame_start(fs_a)
`ifdef VGA_FRAME_CNT_EN
      , .frame_cnt(fc_a)
`endif
   );

   vga_sync_gen #(
      .CLK_DIV(B_DIV),
      .H_DISPLAY(B_HD), .H_FRONT(B_HF), .H_SYNC(B_HS), .H_BACK(B_HB),
      .V_DISPLAY(B_VD), .V_FRONT(B_VF), .V_SYNC(B_VS), .V_BACK(B_VB)
   ) dut_b (
      .clk(clk), .reset(rst_b), .p_tick(tick_b), .x(x_b), .y(y_b),
      .video_on(vid_b), .hsync(hs_b), .vsync(vs_b),
      .line_end(le_b), .frame_start(fs_b)
`ifdef VGA_FRAME_CNT_EN
      , .frame_cnt(fc_b)
`endif
   );

   vga_sync_gen #(.CLK_DIV(1)) dut_c (
      .clk(clk), .reset(rst_c), .p_tick(tick_c), .x(x_c), .y(y_c),
      .video_on(vid_c), .hsync(hs_c), .vsync(vs_c),
      .line_end(le_c), .frame_start(fs_c)
`ifdef VGA_FRAME_CNT_EN
      , .frame_cnt(fc_c)
`endif
   );

`ifndef VGA_FRAME_CNT_EN
   assign fc_a = 8'd0;
   assign fc_b = 8'd0;
   assign fc_c = 8'd0;
`endif

   // Closed-form raster position for cycle t after reset release.
   function automatic exp_t model(int t, int cd, int hd, int hf, int hs, int hb,
                                  int vd, int vf, int vs, int vb);
      exp_t e;
      int p, ht, vt, xx, yy;
      ht = hd + hf + hs + hb;
      vt = vd + vf + vs + vb;
      p  = t / cd;
      xx = p % ht;
      yy = (p / ht) % vt;
      e.x    = 10'(xx);
      e.y    = 10'(yy);
      e.tick = ((t % cd) == cd - 1);
      e.vid  = (xx < hd) && (yy < vd);
      e.hs   = !((xx >= hd + hf) && (xx < hd + hf + hs));
      e.vs   = !((yy >= vd + vf) && (yy < vd + vf + vs));
      e.le   = e.tick && (xx == ht - 1);
      e.fs   = e.le && (yy == vt - 1);
`ifdef VGA_FRAME_CNT_EN
      e.fc   = 8'((p / (ht * vt)) % 256);
`else
      e.fc   = 8'd0;
`endif
      return e;
   endfunction

   task automatic chk_int(string tag, int obs, int expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   // Push the model's value for this cycle, then pop and compare with the DUT.
   task automatic step(int which, int t, string tag);
      exp_t obs, expv;
      case (which)
         0: begin
            sb_q.push_back(model(t, 4, 640, 16, 96, 48, 480, 10, 2, 33));
            obs = '{x_a, y_a, tick_a, vid_a, hs_a, vs_a, le_a, fs_a, fc_a};
            if (t < 3200) begin
               if (!obs.hs) a_hs_low++;
               if (obs.le)  a_le++;
            end
         end
         1: begin
            sb_q.push_back(model(t, B_DIV, B_HD, B_HF, B_HS, B_HB,
                                 B_VD, B_VF, B_VS, B_VB));
            obs = '{x_b, y_b, tick_b, vid_b, hs_b, vs_b, le_b, fs_b, fc_b};
            if (t < B_FRAMES * B_FRAME_CLKS && obs.fs) b_fs++;
            if (t < B_FRAME_CLKS) begin
               if (obs.tick && obs.vid) b_vid_ticks++;
               if (!obs.vs) b_vs_low++;
            end
         end
         default: begin
            sb_q.push_back(model(t, 1, 640, 16, 96, 48, 480, 10, 2, 33));
            obs = '{x_c, y_c, tick_c, vid_c, hs_c, vs_c, le_c, fs_c, fc_c};
            if (t < 800 && obs.le) c_le++;
            if (!obs.tick) c_tick_low++;
         end
      endcase
      expv = sb_q.pop_front();
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s t=%0d observed x=%0d y=%0d tick=%b vid=%b hs=%b vs=%b le=%b fs=%b fc=%0d expected x=%0d y=%0d tick=%b vid=%b hs=%b vs=%b le=%b fs=%b fc=%0d",
                tag, t, obs.x, obs.y, obs.tick, obs.vid, obs.hs, obs.vs, obs.le, obs.fs, obs.fc,
                expv.x, expv.y, expv.tick, expv.vid, expv.hs, expv.vs, expv.le, expv.fs, expv.fc);
      end
   endtask

   initial begin
      // Hold every instance in reset and check the reset state.
      repeat (3) @(negedge clk);
      step(0, 0, "reset_a");
      step(1, 0, "reset_b");
      step(2, 0, "reset_c");
      @(negedge clk);
      step(0, 0, "reset_a");
      step(2, 0, "reset_c");

      // Instance A: one full line and part of the next, up to x=300, y=1.
      rst_a = 1'b0;
      step(0, 0, "a_scan");
      for (int t = 1; t <= 4403; t++) begin
         @(negedge clk);
         step(0, t, "a_scan");
      end
      chk_int("a_hsync_low_clocks", a_hs_low, 384);
      chk_int("a_line_end_pulses", a_le, 1);

      // Reset for one cycle on a tick cycle at x=300: reset must win.
      rst_a = 1'b1;
      @(negedge clk);
      rst_a = 1'b0;
      step(0, 0, "a_mid_reset");
      for (int t = 1; t <= 12; t++) begin
         @(negedge clk);
         step(0, t, "a_after_reset");
      end

      // Instance C: CLK_DIV=1, tick constant and an 800-clock line.
      rst_c = 1'b0;
      step(2, 0, "c_scan");
      for (int t = 1; t <= 810; t++) begin
         @(negedge clk);
         step(2, t, "c_scan");
      end
      chk_int("c_line_end_pulses", c_le, 1);
      chk_int("c_tick_low_cycles", c_tick_low, 0);

      // Instance B: whole frames of a shrunken raster.
      rst_b = 1'b0;
      step(1, 0, "b_frame");
      for (int t = 1; t <= B_FRAMES * B_FRAME_CLKS + 4; t++) begin
         @(negedge clk);
         step(1, t, "b_frame");
      end
      chk_int("b_frame_start_pulses", b_fs, B_FRAMES);
      chk_int("b_video_on_ticks", b_vid_ticks, B_HD * B_VD);
      chk_int("b_vsync_low_clocks", b_vs_low, B_VS * 10 * B_DIV);
      chk_int("sb_queue_empty", sb_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
